data_mem_ctrl: RTL and testbench

Parametrised, word-organised, byte-addressed data memory for the multicycle RISC-V core, replacing the flat byte array used by the load/store path. Adds RV32I access sizes with sign/zero extension, a valid/ready request handshake, configurable wait-state latency, and a sequential clear-after-reset engine. A registered response carries the load data and a fault flag. Sits between the core's memory stage and the memory-data register.

---
 rtl/data_mem_ctrl.sv | 170 +++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: word-organised, byte-addressed data memory for the multicycle core.
// RV32I load/store sizes with sign/zero extension, valid/ready request handshake,
// WAIT_CYCLES extra access cycles, and a one-word-per-cycle clear after reset.
// Build option: define MEM_MISALIGN_TRAP_EN to fault on misaligned accesses;
// otherwise misaligned addresses are aligned down and complete normally.

// One byte lane of storage: single index shared by the read and write paths.
module data_mem_lane #(
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] idx,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);
  logic [7:0] mem [2**AW];

  // byte write; the read is combinational and registered by the controller
  always_ff @(posedge clk) if (we) mem[idx] <= wdata;

  assign rdata = mem[idx];
endmodule

module data_mem_ctrl #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic        init_done
);
  localparam int NUM_LANES = 4;
  localparam int AW        = ADDR_W - 2;

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

  typedef struct packed {
    logic              write;
    logic [2:0]        funct3;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
  } req_t;

  state_t                         state, state_nx;
  req_t                           req_q;
  logic [AW-1:0]                  clr_ptr;
  logic [3:0]                     wcnt;
  logic [NUM_LANES-1:0]           lane_we, be;
  logic [NUM_LANES-1:0][7:0]      lane_wd, lane_rd;
  logic [AW-1:0]                  lane_idx;
  logic [1:0]                     sz, lane;
  logic                           illegal, fault;
  logic [31:0]                    rword, wd32, ld, rdata_nx;
  logic [15:0]                    sh;
  logic                           addr_unused;

  // upper address bits are ignored: addresses wrap modulo 2^ADDR_W
  assign addr_unused = ^req_addr[31:ADDR_W];

  assign sz       = req_q.funct3[1:0];
  assign lane_idx = (state == S_INIT) ? clr_ptr : req_q.addr[ADDR_W-1:2];
  assign rword    = lane_rd;
  assign sh       = 16'(rword >> {lane, 3'b000});
  assign illegal  = (sz == 2'd3) || (req_q.funct3 == 3'b110) || (req_q.write && req_q.funct3[2]);

  // access decode: fault, effective lane, byte enables, store data and load extraction
  always_comb begin
`ifdef MEM_MISALIGN_TRAP_EN
    lane  = req_q.addr[1:0];
    fault = illegal || (sz == 2'd1 && req_q.addr[0]) || (sz == 2'd2 && req_q.addr[1:0] != 2'b00);
`else
    lane  = (sz == 2'd0) ? req_q.addr[1:0] : (sz == 2'd1) ? {req_q.addr[1], 1'b0} : 2'b00;
    fault = illegal;
`endif
    be   = 4'b1111;
    wd32 = req_q.wdata;
    ld   = rword;
    case (sz)
      2'd0: begin
        be   = 4'b0001 << lane;
        wd32 = {4{req_q.wdata[7:0]}};
        ld   = req_q.funct3[2] ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      end
      2'd1: begin
        be   = 4'b0011 << lane;
        wd32 = {2{req_q.wdata[15:0]}};
        ld   = req_q.funct3[2] ? {16'h0, sh} : {{16{sh[15]}}, sh};
      end
      default: ;
    endcase
    rdata_nx = (fault || req_q.write) ? 32'h0 : ld;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      // clear writes zero during INIT; a store only writes on its ACCESS edge
      assign lane_we[gi] = reset && ((state == S_INIT) ||
                           (state == S_ACCESS && req_q.write && !fault && be[gi]));
      assign lane_wd[gi] = (state == S_INIT) ? 8'h00 : wd32[8*gi +: 8];
      data_mem_lane #(.AW(AW)) u_lane (
        .clk   (clk),
        .we    (lane_we[gi]),
        .idx   (lane_idx),
        .wdata (lane_wd[gi]),
        .rdata (lane_rd[gi])
      );
    end
  endgenerate

  // state register, clear pointer, request capture, wait counter, response registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_INIT;
      clr_ptr   <= '0;
      wcnt      <= '0;
      req_q     <= '0;
      init_done <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_fault <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_INIT) begin
        clr_ptr <= clr_ptr + 1'b1;
        if (clr_ptr == '1) init_done <= 1'b1;
      end
      if (state == S_IDLE && req_valid) begin
        req_q <= '{write: req_write, funct3: req_funct3,
                   addr: req_addr[ADDR_W-1:0], wdata: req_wdata};
        wcnt  <= 4'(WAIT_CYCLES - 1);
      end
      if (state == S_WAIT) wcnt <= wcnt - 1'b1;
      if (state == S_ACCESS) begin
        rsp_rdata <= rdata_nx;
        rsp_fault <= fault;
      end
    end
  end

  // next state and handshake outputs
  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      S_INIT:   if (clr_ptr == '1) state_nx = S_IDLE;
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nx = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
      end
      S_WAIT:   if (wcnt == 4'd0) state_nx = S_ACCESS;
      S_ACCESS: state_nx = S_RESP;
      S_RESP: begin
        rsp_valid = 1'b1;
        state_nx  = S_IDLE;
      end
      default:  state_nx = S_INIT;
    endcase
  end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: two instances (WAIT_CYCLES=1 and 0) share the stimulus;
// a byte-array model per instance predicts every output on every cycle.
module tb_data_mem_ctrl;
  localparam int MB    = 256;
  localparam int WORDS = MB / 4;

  logic clk = 1'b0, reset = 1'b0, req_valid = 1'b0, req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic [1:0]  rdy, rv, rf, idn;
  logic [1:0][31:0] rd;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, rel = 0;
  bit rst_seen = 1'b0;
  int due [2];
  logic [7:0]  mm [2][MB];
  logic        pw [2];
  logic [2:0]  pf [2];
  logic [31:0] pa [2], pd [2], hold_rd [2];
  logic        hold_ft [2];

  always #5 clk = ~clk;

  data_mem_ctrl u_dut0 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy[0]),
    .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rv[0]), .rsp_rdata(rd[0]),
    .rsp_fault(rf[0]), .init_done(idn[0])
  );

  data_mem_ctrl #(.ADDR_W(8), .WAIT_CYCLES(0)) u_dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy[1]),
    .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rv[1]), .rsp_rdata(rd[1]),
    .rsp_fault(rf[1]), .init_done(idn[1])
  );

  function automatic int wc(int k);
    return (k == 0) ? 1 : 0;
  endfunction

  function automatic bit m_ready(int k, int c);
    return rst_seen && (c >= rel + WORDS) && (c > due[k]);
  endfunction

  // perform the pending access of instance k on the model memory
  function automatic void m_exec(int k);
    int ba, sz;
    logic ill, mis, flt;
    logic [31:0] v;
    ba  = int'(pa[k][7:0]);
    ill = (pf[k][1:0] == 2'b11) || (pf[k] == 3'b110) || (pw[k] && pf[k][2]);
    sz  = 1 << pf[k][1:0];
    mis = (ba % sz) != 0;
`ifdef MEM_MISALIGN_TRAP_EN
    flt = ill || mis;
`else
    flt = ill;
    ba  = ba - (ba % sz);
`endif
    v = 32'h0;
    if (!flt && pw[k]) begin
      for (int i = 0; i < sz; i++) mm[k][ba+i] = pd[k][8*i +: 8];
    end else if (!flt) begin
      for (int i = 0; i < sz; i++) v = v | (32'(mm[k][ba+i]) << (8*i));
      if (!pf[k][2] && sz < 4 && v[8*sz-1]) v = v | (32'hFFFFFFFF << (8*sz));
    end
    hold_rd[k] = v;
    hold_ft[k] = flt;
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d cyc=%0d got=%h exp=%h", nm, k, cyc, got, exp);
    end
  endtask

  task automatic timeout_fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s timeout cyc=%0d", nm, cyc);
  endtask

  // model: acceptance, commit on the ACCESS edge, reset abort and clear
  initial begin
    due[0] = -100;
    due[1] = -100;
    forever begin
      @(posedge clk);
      for (int k = 0; k < 2; k++)
        if (reset && req_valid && m_ready(k, cyc)) begin
          pw[k] = req_write; pf[k] = req_funct3; pa[k] = req_addr; pd[k] = req_wdata;
          due[k] = cyc + 2 + wc(k);
        end
      cyc++;
      if (!reset) begin
        rst_seen = 1'b1;
        rel = cyc;
        for (int k = 0; k < 2; k++) begin
          due[k] = -100; hold_rd[k] = 32'h0; hold_ft[k] = 1'b0;
          for (int i = 0; i < MB; i++) mm[k][i] = 8'h00;
        end
      end else begin
        for (int k = 0; k < 2; k++) if (cyc == due[k]) m_exec(k);
      end
    end
  end

  // compare every output of both instances against the model each cycle
  initial forever begin
    @(negedge clk);
    if (rst_seen)
      for (int k = 0; k < 2; k++) begin
        chk("init_done", k, 32'(idn[k]), 32'(cyc >= rel + WORDS));
        chk("req_ready", k, 32'(rdy[k]), 32'(m_ready(k, cyc)));
        chk("rsp_valid", k, 32'(rv[k]), 32'(cyc == due[k]));
        chk("rsp_rdata", k, rd[k], hold_rd[k]);
        chk("rsp_fault", k, 32'(rf[k]), 32'(hold_ft[k]));
      end
  end

  task automatic wait_ready(output bit ok);
    int n;
    n = 0;
    ok = 1'b1;
    @(negedge clk);
    while (!(rdy[0] && rdy[1]) && n < 300) begin n++; @(negedge clk); end
    if (n >= 300) begin timeout_fail("wait_ready"); ok = 1'b0; end
  endtask

  // issue one request to both instances; return dut0's response
  task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] r, output logic f);
    int t0, ta, tb, n;
    bit ok;
    r = 32'h0; f = 1'b0; ta = -1; tb = -1; n = 0;
    wait_ready(ok);
    if (!ok) return;
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = d;
    t0 = cyc;
    do begin
      @(negedge clk);
      n++;
      if (rv[0] && ta < 0) begin ta = cyc; r = rd[0]; f = rf[0]; end
      if (rv[1] && tb < 0) tb = cyc;
      // noise while both are busy must be ignored and must not disturb the request
      req_valid  = (!rdy[0] && !rdy[1]) ? 1'($urandom_range(0, 1)) : 1'b0;
      req_write  = 1'($urandom_range(0, 1));
      req_funct3 = 3'($urandom_range(0, 7));
      req_addr   = $urandom;
      req_wdata  = $urandom;
    end while (ta < 0 && n < 40);
    req_valid = 1'b0;
    if (ta < 0) begin timeout_fail("rsp_wait"); return; end
    chk("lat_wait1", 0, 32'(ta - t0), 32'd3);
    chk("lat_wait0", 1, 32'(tb - t0), 32'd2);
    @(negedge clk);
    chk("ready_after", 0, 32'(rdy[0]), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic f;
    int pulses, n;
    bit ok;

    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 1; i <= 65; i++) begin
      @(negedge clk);
      if (i == 64) chk("init_lo64", 0, 32'(idn[0]), 32'd0);
      if (i == 65) chk("init_hi65", 0, 32'(idn[0]), 32'd1);
    end

    do_req(1'b0, 3'b010, 32'h0000_00FC, 32'h0, r, f); chk("lw_fc_clear", 0, r, 32'h0);

    do_req(1'b1, 3'b010, 32'h10, 32'h80FF7F01, r, f);
    do_req(1'b0, 3'b000, 32'h10, 32'h0, r, f); chk("lb_10", 0, r, 32'h00000001);
    do_req(1'b0, 3'b000, 32'h12, 32'h0, r, f); chk("lb_12", 0, r, 32'hFFFFFFFF);
    do_req(1'b0, 3'b100, 32'h13, 32'h0, r, f); chk("lbu_13", 0, r, 32'h00000080);
    do_req(1'b0, 3'b001, 32'h12, 32'h0, r, f); chk("lh_12", 0, r, 32'hFFFF80FF);
    do_req(1'b0, 3'b101, 32'h10, 32'h0, r, f); chk("lhu_10", 0, r, 32'h00007F01);

    do_req(1'b1, 3'b010, 32'h20, 32'h11223344, r, f);
    do_req(1'b1, 3'b000, 32'h21, 32'h000000AA, r, f); chk("sb_fault", 0, 32'(f), 32'd0);
    do_req(1'b0, 3'b010, 32'h20, 32'h0, r, f); chk("lw_20_merge", 0, r, 32'h1122AA44);

    do_req(1'b1, 3'b010, 32'h30, 32'h01020304, r, f);
    do_req(1'b1, 3'b010, 32'h31, 32'hDEADBEEF, r, f);
`ifdef MEM_MISALIGN_TRAP_EN
    chk("sw_mis_fault", 0, 32'(f), 32'd1);
    chk("sw_mis_rdata", 0, r, 32'h0);
    do_req(1'b0, 3'b010, 32'h30, 32'h0, r, f); chk("lw_30_kept", 0, r, 32'h01020304);
`else
    chk("sw_mis_fault", 0, 32'(f), 32'd0);
    do_req(1'b0, 3'b010, 32'h30, 32'h0, r, f); chk("lw_30_aligned", 0, r, 32'hDEADBEEF);
`endif
    do_req(1'b0, 3'b011, 32'h30, 32'h0, r, f);
    chk("f3_011_fault", 0, 32'(f), 32'd1);
    chk("f3_011_rdata", 0, r, 32'h0);
    do_req(1'b1, 3'b100, 32'h30, 32'h55, r, f); chk("sbu_fault", 0, 32'(f), 32'd1);
    do_req(1'b0, 3'b010, 32'h1_0010, 32'h0, r, f); chk("lw_wrap", 0, r, 32'h80FF7F01);

    for (int i = 0; i < 80; i++)
      do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             ($urandom & 32'hFFFFFF00) | 32'($urandom_range(0, 63)), $urandom, r, f);

    // reset during the wait of a store: no response, store discarded, full re-clear
    wait_ready(ok);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h40; req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1 reset = 1'b0; req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    pulses = 0; n = 0;
    @(negedge clk);
    while (!(rdy[0] && rdy[1]) && n < 300) begin
      if (rv != 2'b00) pulses++;
      n++;
      @(negedge clk);
    end
    if (n >= 300) timeout_fail("reinit");
    chk("abort_no_pulse", 0, 32'(pulses), 32'd0);
    do_req(1'b0, 3'b010, 32'h40, 32'h0, r, f); chk("abort_lw_40", 0, r, 32'h0);
    do_req(1'b0, 3'b010, 32'h10, 32'h0, r, f); chk("reclear_lw_10", 0, r, 32'h0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
